rca_bist_repair_ctrl: RTL and testbench

// Built-in self-test and repair controller for a 4-bit double-fault-tolerant ripple-carry adder.
// - Fault model: the adder has 4 primary full-adder (FA) cells and 2 spare FA cells.
// - This block generates 8 test vectors and compares the adder's per-cell sum/carry outputs with golden values.
// - It accumulates a per-cell fault map and drives the adder's spare/bypass mux selects.
// - It combines the three functions: pattern generator, golden-compare LUT, and mux-select generator.

---
 rtl/rca_bist_repair_ctrl.sv | 116 +++++++++++
 tb/tb_rca_bist_repair_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rca_bist_repair_ctrl.sv
// BIST and spare-cell repair controller for a 4-bit ripple-carry adder with two spare FA cells.
// Drives 8 test vectors, checks each cell's sum and carry, and registers the spare mux selects when the run ends.
module rca_bist_repair_ctrl (
  input  logic       clk,
  input  logic       init_n,
  input  logic       test,
  input  logic [3:0] adder_sums,
  input  logic [3:0] adder_carrys,
  output logic [3:0] at,
  output logic [3:0] bt,
  output logic       cint,
  output logic [2:0] count,
  output logic [7:0] comp,
  output logic [2:0] is0,
  output logic [2:0] is1,
  output logic [4:0] cs,
  output logic [3:0] ss0,
  output logic [3:0] ss1,
  output logic       done,
  output logic       unrepairable
);

  logic       r_test_q, r_done, r_unrep, r_rvalid;
  logic [2:0] r_count, r_is0, r_is1;
  logic [3:0] r_fault;

  logic       w_rise, w_active;
  logic [2:0] w_idx, w_n0, w_n1, w_nf;
  logic [3:0] w_a, w_b, w_es, w_ec, w_cellf, w_fault_nxt;
  logic       w_c;

  // The restart edge also samples vector 0, so a run is 8 cycles counted from the rise.
  assign w_rise   = test & ~r_test_q;
  assign w_idx    = w_rise ? 3'd0 : r_count;
  assign w_active = test & (w_rise | ~r_done);

  always_comb begin
    {w_a, w_b, w_c, w_es, w_ec} = '0;
    case (w_idx)
      3'd0: {w_a, w_b, w_c, w_es, w_ec} = {4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000};
      3'd1: {w_a, w_b, w_c, w_es, w_ec} = {4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111};
      3'd2: {w_a, w_b, w_c, w_es, w_ec} = {4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000};
      3'd3: {w_a, w_b, w_c, w_es, w_ec} = {4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000};
      3'd4: {w_a, w_b, w_c, w_es, w_ec} = {4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b1111};
      3'd5: {w_a, w_b, w_c, w_es, w_ec} = {4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111};
      3'd6: {w_a, w_b, w_c, w_es, w_ec} = {4'b0101, 4'b0101, 1'b0, 4'b1010, 4'b0101};
      default: {w_a, w_b, w_c, w_es, w_ec} = {4'b1010, 4'b1010, 1'b1, 4'b0101, 4'b1010};
    endcase
  end

  assign at    = w_active ? w_a : 4'b0000;
  assign bt    = w_active ? w_b : 4'b0000;
  assign cint  = w_active & w_c;
  assign count = w_idx;
  assign comp  = w_active ? {adder_carrys ^ w_ec, adder_sums ^ w_es} : 8'h00;

  assign w_cellf     = comp[3:0] | comp[7:4];
  assign w_fault_nxt = (w_rise ? 4'b0000 : r_fault) | w_cellf;

  // First and second faulty cell indices plus the faulty-cell count.
  always_comb begin
    w_n0 = 3'd4;
    w_n1 = 3'd4;
    w_nf = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_fault_nxt[i]) begin
        if (w_nf == 3'd0)      w_n0 = 3'(i);
        else if (w_nf == 3'd1) w_n1 = 3'(i);
        w_nf = w_nf + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_test_q <= 1'b0;
      r_count  <= 3'd0;
      r_fault  <= 4'b0000;
      r_done   <= 1'b0;
      r_unrep  <= 1'b0;
      r_rvalid <= 1'b0;
      r_is0    <= 3'd4;
      r_is1    <= 3'd4;
    end else begin
      r_test_q <= test;
      if (w_rise) begin
        r_done   <= 1'b0;
        r_unrep  <= 1'b0;
        r_rvalid <= 1'b0;
        r_is0    <= 3'd4;
        r_is1    <= 3'd4;
      end
      if (w_active) begin
        r_fault <= w_fault_nxt;
        if (w_idx == 3'd7) begin
          r_done   <= 1'b1;
          r_is0    <= w_n0;
          r_is1    <= w_n1;
          r_rvalid <= (w_nf <= 3'd2);
          r_unrep  <= (w_nf > 3'd2);
        end else begin
          r_count <= w_idx + 3'd1;
        end
      end
    end
  end

  assign is0          = r_is0;
  assign is1          = r_is1;
  assign ss0          = r_is0[2] ? 4'b0000 : (4'b0001 << r_is0[1:0]);
  assign ss1          = r_is1[2] ? 4'b0000 : (4'b0001 << r_is1[1:0]);
  assign cs           = {r_rvalid, ss0 | ss1};
  assign done         = r_done;
  assign unrepairable = r_unrep;

endmodule

// File: tb/tb_rca_bist_repair_ctrl.sv
// Directed bench for rca_bist_repair_ctrl: a per-cell adder model with stuck-at injection
// feeds the controller; expected selects and flags are hand-derived constants.
module tb_rca_bist_repair_ctrl;

  logic       clk, init_n, test;
  logic [3:0] adder_sums, adder_carrys;
  logic [3:0] at, bt;
  logic       cint;
  logic [2:0] count;
  logic [7:0] comp;
  logic [2:0] is0, is1;
  logic [4:0] cs;
  logic [3:0] ss0, ss1;
  logic       done, unrepairable;

  logic [3:0] sa0_s, sa1_s, sa0_c, sa1_c;
  logic [3:0] ms, mc;
  logic       gc;
  int         tests, fails;

  rca_bist_repair_ctrl dut (
    .clk(clk), .init_n(init_n), .test(test),
    .adder_sums(adder_sums), .adder_carrys(adder_carrys),
    .at(at), .bt(bt), .cint(cint), .count(count), .comp(comp),
    .is0(is0), .is1(is1), .cs(cs), .ss0(ss0), .ss1(ss1),
    .done(done), .unrepairable(unrepairable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cell sees the fault-free carry chain so a fault shows only on its own cell.
  always_comb begin
    gc = cint;
    ms = 4'b0000;
    mc = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ms[i] = at[i] ^ bt[i] ^ gc;
      mc[i] = (at[i] & bt[i]) | (gc & (at[i] ^ bt[i]));
      gc    = mc[i];
    end
  end
  assign adder_sums   = (ms & ~sa0_s) | sa1_s;
  assign adder_carrys = (mc & ~sa0_c) | sa1_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run8();
    test = 1'b1;
    cyc(8);
  endtask

  task automatic idle();
    test = 1'b0;
    cyc(1);
  endtask

  initial begin
    tests = 0; fails = 0;
    init_n = 1'b0; test = 1'b0;
    sa0_s = '0; sa1_s = '0; sa0_c = '0; sa1_c = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_unrep", unrepairable, 0);
    chk("rst_is0", is0, 4);
    chk("rst_is1", is1, 4);
    chk("rst_cs", cs, 0);
    chk("rst_ss", {ss1, ss0}, 0);
    chk("rst_at", {at, bt, cint}, 0);
    init_n = 1'b1;
    cyc(1);

    // 1: fault-free
    test = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t1_count", count, k);
      chk("t1_comp", comp, 0);
      cyc(1);
    end
    chk("t1_done", done, 1);
    chk("t1_is", {is1, is0}, {3'd4, 3'd4});
    chk("t1_cs", cs, 5'b10000);
    chk("t1_ss", {ss1, ss0}, 0);
    chk("t1_unrep", unrepairable, 0);
    chk("t1_count_hold", count, 7);
    chk("t1_ops_off", {at, bt, cint}, 0);
    idle();
    chk("t1_mission_cs", cs, 5'b10000);
    chk("t1_mission_done", done, 1);

    // 2: cell 2 sum stuck-at-0, seen at vectors 1,2,3,7
    sa0_s = 4'b0100;
    test = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_comp", comp, (k == 1 || k == 2 || k == 3 || k == 7) ? 8'h04 : 8'h00);
      cyc(1);
    end
    chk("t2_is0", is0, 2);
    chk("t2_is1", is1, 4);
    chk("t2_ss0", ss0, 4'b0100);
    chk("t2_ss1", ss1, 4'b0000);
    chk("t2_cs", cs, 5'b10100);
    idle();

    // 3: cell 0 carry stuck-at-1, cell 3 sum stuck-at-1
    sa0_s = 4'b0000; sa1_c = 4'b0001; sa1_s = 4'b1000;
    run8();
    chk("t3_is0", is0, 0);
    chk("t3_is1", is1, 3);
    chk("t3_ss0", ss0, 4'b0001);
    chk("t3_ss1", ss1, 4'b1000);
    chk("t3_cs", cs, 5'b11001);
    chk("t3_unrep", unrepairable, 0);
    idle();

    // 4: cells 0,1,3 faulty
    sa1_c = 4'b0000; sa1_s = 4'b0000; sa0_s = 4'b1011;
    run8();
    chk("t4_unrep", unrepairable, 1);
    chk("t4_cs4", cs[4], 0);
    chk("t4_cs", cs, 5'b00011);
    chk("t4_is0", is0, 0);
    chk("t4_is1", is1, 1);
    idle();

    // 5: abort at count 4 with a detected fault, then restart fault-free
    sa0_s = 4'b0100;
    test = 1'b1;
    cyc(4);
    chk("t5_count4", count, 4);
    test = 1'b0;
    #1;
    chk("t5_ops_off", {at, bt, cint}, 0);
    chk("t5_comp_off", comp, 0);
    chk("t5_sel_id", {is1, is0}, {3'd4, 3'd4});
    chk("t5_cs_id", cs, 0);
    chk("t5_unrep_clr", unrepairable, 0);
    chk("t5_not_done", done, 0);
    cyc(3);
    chk("t5_count_frozen", count, 4);
    sa0_s = 4'b0000;
    test = 1'b1;
    #1;
    chk("t5_restart0", count, 0);
    cyc(1);
    chk("t5_restart1", count, 1);
    cyc(7);
    chk("t5_done", done, 1);
    chk("t5_flags_clr", is0, 4);
    chk("t5_cs", cs, 5'b10000);
    idle();

    // 6: async reset at count 5
    sa0_s = 4'b1000;
    test = 1'b1;
    cyc(5);
    chk("t6_count5", count, 5);
    #2 init_n = 1'b0;
    #1;
    chk("t6_done", done, 0);
    chk("t6_count", count, 0);
    chk("t6_is", {is1, is0}, {3'd4, 3'd4});
    chk("t6_cs", cs, 0);
    chk("t6_unrep", unrepairable, 0);
    test = 1'b0;
    #1;
    chk("t6_count_reg", count, 0);
    chk("t6_ops", {at, bt, cint}, 0);
    @(negedge clk);
    init_n = 1'b1;
    sa0_s = 4'b0000;
    cyc(1);
    run8();
    chk("t6_post_done", done, 1);
    chk("t6_post_cs", cs, 5'b10000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
